// File: rtl/dmem_responder.sv
// Data-memory responder for the mem stage: one request at a time,
// fixed-latency response, byte-lane stores, misaligned/out-of-range errors.
module dmem_responder #(
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam state_t S_START = (LATENCY == 1) ? S_RESP : S_WAIT;
  localparam logic START_COMMIT = (LATENCY == 1);

  state_t r_state;
  state_t w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_c_we;
  logic        w_c_err;
  logic [31:0] w_c_addr;
  logic [31:0] w_c_wdata;
  logic [3:0]  w_c_be;
  logic [AW-1:0] w_idx;

  logic [31:0] data_mem [MEM_WORDS];

  assign req_ready = !reset &&
    ((r_state == S_IDLE) ||
     ((r_state == S_RESP) && resp_ready));
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Commit from WAIT uses the captured request; a one-cycle
  // latency commits the live request on its own accept edge.
  assign w_c_we    = (r_state == S_WAIT) ? r_we    : req_we;
  assign w_c_addr  = (r_state == S_WAIT) ? r_addr  : req_addr;
  assign w_c_wdata = (r_state == S_WAIT) ? r_wdata : req_wdata;
  assign w_c_be    = (r_state == S_WAIT) ? r_be    : req_be;

  assign w_c_err = (w_c_addr[1:0] != 2'b00) ||
    ({2'b00, w_c_addr[31:2]} >= 32'(MEM_WORDS));
  assign w_idx = w_c_addr[AW+1:2];

  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next   = S_START;
          w_cnt    = CW'(LATENCY - 1);
          w_commit = START_COMMIT;
        end
      end
      S_WAIT: begin
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
          if (w_accept) begin
            w_next   = S_START;
            w_cnt    = CW'(LATENCY - 1);
            w_commit = START_COMMIT;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_commit) begin
        r_err   <= w_c_err;
        r_rdata <= (w_c_err || w_c_we) ? '0 : data_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
    if (w_commit && w_c_we && !w_c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_be[i])
          data_mem[w_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=4 (u0) and LATENCY=1 (u1)
// driven against a word-array reference model.
module tb_dmem_responder;

  localparam int MW = 65536;
  localparam int NW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [1:0]  resp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be [2];
  logic [31:0] resp_rdata [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit [31:0] mdl [2][NW];

  typedef struct {
    bit [31:0] rdata;
    bit        err;
    int        acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit [1:0] seen;
  bit [1:0] rr_rand;
  int last_hs [2];

  dmem_responder #(.MEM_WORDS(MW), .LATENCY(4)) u0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.MEM_WORDS(MW), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rr_rand[0]) resp_ready[0] = ($urandom_range(0, 3) != 0);
    if (rr_rand[1]) resp_ready[1] = ($urandom_range(0, 3) != 0);
  end

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic bit [31:0] mem_rd(input int k, input int w);
    if (k == 0) return u0.data_mem[16'(w)];
    return u1.data_mem[16'(w)];
  endfunction

  task automatic mem_wr(input int k, input int w, input bit [31:0] v);
    if (k == 0) u0.data_mem[16'(w)] = v;
    else u1.data_mem[16'(w)] = v;
    if (w < NW) mdl[k][w] = v;
  endtask

  task automatic chk(input string nm, input bit [31:0] act,
                     input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(input int k, input bit we, input bit [31:0] a,
                       input bit [31:0] wd, input bit [3:0] be,
                       input bit track, output int acc);
    bit ok;
    exp_t e;
    int w;
    ok = 1'b0;
    req_we[k] = we;
    req_addr[k] = a;
    req_wdata[k] = wd;
    req_be[k] = be;
    req_valid[k] = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready[k];
    end
    acc = cyc;
    chk("accept_timeout", 32'(ok), 32'd1);
    if (!ok) begin
      req_valid[k] = 1'b0;
      return;
    end
    if (track) begin
      w = int'(a >> 2);
      e.err = (a[1:0] != 2'b00) || ((a >> 2) >= MW);
      e.rdata = '0;
      e.acc = acc;
      if (!e.err && w < NW) begin
        if (we) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) mdl[k][w][8*i +: 8] = wd[8*i +: 8];
        end else begin
          e.rdata = mdl[k][w];
        end
      end
      qpush(k, e);
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic mon_step(input int k);
    exp_t h;
    if (rst[k]) begin
      seen[k] = 1'b0;
      return;
    end
    if (!resp_valid[k]) return;
    chk("spurious_resp", 32'(qsize(k) != 0), 32'd1);
    if (qsize(k) == 0) return;
    h = (k == 0) ? q0[0] : q1[0];
    if (!seen[k]) begin
      chk("latency", 32'(cyc), 32'(h.acc + lat(k)));
      seen[k] = 1'b1;
    end
    chk("rdata", resp_rdata[k], h.rdata);
    chk("err", 32'(resp_err[k]), 32'(h.err));
    if (resp_ready[k]) begin
      if (k == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      seen[k] = 1'b0;
      last_hs[k] = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic drain(input int k);
    for (int n = 0; n < 2000 && qsize(k) != 0; n++) @(negedge clk);
    chk("drain_timeout", 32'(qsize(k)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int k, input int cnt);
    bit [31:0] a;
    int r;
    int acc;
    for (int n = 0; n < cnt; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      a = {20'd0, 10'($urandom_range(0, NW - 1)), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = 32'($urandom_range(MW, 32'h3FFF_FFFF)) << 2;
      issue(k, 1'($urandom), a, $urandom, 4'($urandom), 1'b1, acc);
    end
    drain(k);
  endtask

  initial begin : main
    int acc;
    int acc2;
    int first;
    bit found;
    rst = 2'b11;
    req_valid = '0;
    req_we = '0;
    resp_ready = '0;
    rr_rand = '0;
    seen = '0;
    last_hs[0] = 0;
    last_hs[1] = 0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = '0;
      req_wdata[k] = '0;
      req_be[k] = '0;
      for (int w = 0; w < NW; w++) mem_wr(k, w, $urandom);
      mem_wr(k, 16'hFFFF, 32'h5A5A_0FF0);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'd0);
      chk("rst_err", 32'(resp_err[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 2'b00;
    @(negedge clk);
    chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    resp_ready = 2'b11;

    issue(0, 1'b1, 32'h80, 32'h0001_0000, 4'hF, 1'b1, acc);
    issue(0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, acc);
    drain(0);
    chk("t1_word", mem_rd(0, 32'h20), 32'h0001_0000);

    mem_wr(0, 32'h40, 32'hAABB_CCDD);
    issue(0, 1'b1, 32'h100, 32'h1122_3344, 4'b0101, 1'b1, acc);
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, acc);
    drain(0);
    chk("t2_word", mem_rd(0, 32'h40), 32'hAA22_CC44);

    issue(0, 1'b0, 32'h102, 32'h0, 4'hF, 1'b1, acc);
    issue(0, 1'b1, 32'h4_0000, 32'h7777_7777, 4'hF, 1'b1, acc);
    drain(0);
    chk("t3_top_word", mem_rd(0, 16'hFFFF), 32'h5A5A_0FF0);
    chk("t3_word0", mem_rd(0, 0), mdl[0][0]);

    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, acc);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      found = resp_valid[0];
    end
    chk("t4_valid_seen", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", 32'(resp_valid[0]), 32'd1);
      chk("t4_hold_ready", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b1;
    issue(0, 1'b0, 32'h48, 32'h0, 4'h0, 1'b1, acc2);
    chk("t4_same_edge", 32'(last_hs[0]), 32'(acc2));
    drain(0);

    for (int k = 0; k < 2; k++) begin
      first = 0;
      for (int i = 0; i < 8; i++) begin
        issue(k, 1'b0, {20'd0, 10'($urandom_range(0, NW - 1)), 2'b00},
              32'h0, 4'h0, 1'b1, acc);
        if (i == 0) first = acc;
      end
      drain(k);
      chk("t5_throughput", 32'(last_hs[k] - first), 32'(8 * lat(k)));
    end

    issue(0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", 32'(req_ready[0]), 32'd0);
    chk("t6_rst_valid", 32'(resp_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t6_rel_ready", 32'(req_ready[0]), 32'd1);
    chk("t6_rel_valid", 32'(resp_valid[0]), 32'd0);
    chk("t6_word", mem_rd(0, 32'h80), mdl[0][32'h80]);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    rr_rand = 2'b11;
    fork
      rand_run(0, 150);
      rand_run(1, 150);
    join
    rr_rand = 2'b00;
    #2;
    resp_ready = 2'b11;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < NW; w++)
        chk("final_mem", mem_rd(k, w), mdl[k][w]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
